// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter: one registered one-hot grant at a time, held until the transfer
// completes, the requester withdraws, or the hold watchdog expires.
module bus_rr_arbiter #(
  parameter int unsigned CPUS          = 8,
  parameter int unsigned CPU_ID_LENGTH = $clog2(CPUS),
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          req,
  input  logic                     bus_idle,
  input  logic                     xfer_done,
  output logic [CPUS-1:0]          grant,
  output logic                     grant_valid,
  output logic [CPU_ID_LENGTH-1:0] grant_id,
  output logic                     timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ArbIdle, ArbGrant, ArbRelease} state_e;

  state_e                   state_q, state_d;
  logic [CPUS-1:0]          grant_q, grant_d;
  logic                     grant_valid_q, grant_valid_d;
  logic [CPU_ID_LENGTH-1:0] grant_id_q, grant_id_d;
  logic [CPU_ID_LENGTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]          hold_cnt_q, hold_cnt_d;
  logic                     timeout_err_q, timeout_err_d;

  logic                     sel_found;
  logic [CPU_ID_LENGTH-1:0] sel_id;
  logic                     granted_req;
  logic                     hold_expired;
  logic                     release_now;

  // Search starts just after the last served CPU and wraps modulo CPUS.
  always_comb begin
    int unsigned              pos;
    logic [CPU_ID_LENGTH-1:0] cand;
    sel_found = 1'b0;
    sel_id    = '0;
    pos       = 0;
    cand      = '0;
    for (int unsigned i = 1; i <= CPUS; i++) begin
      pos = int'(rr_ptr_q) + i;
      if (pos >= CPUS) pos = pos - CPUS;
      cand = CPU_ID_LENGTH'(pos);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  assign granted_req  = req[grant_id_q];
  assign hold_expired = (hold_cnt_q == CntW'(TIMEOUT - 1));
  assign release_now  = xfer_done | ~granted_req | hold_expired;

  always_ff @(posedge clk) begin
    if (nRST) begin
      state_q       <= ArbIdle;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= CPU_ID_LENGTH'(CPUS - 1);
      hold_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ArbIdle:    if (bus_idle && sel_found) state_d = ArbGrant;
      ArbGrant:   if (release_now) state_d = ArbRelease;
      ArbRelease: state_d = ArbIdle;
      default:    state_d = ArbIdle;
    endcase
  end

  always_comb begin
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    hold_cnt_d    = hold_cnt_q;
    timeout_err_d = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
        if (bus_idle && sel_found) begin
          grant_d       = CPUS'(1) << sel_id;
          grant_valid_d = 1'b1;
          grant_id_d    = sel_id;
          hold_cnt_d    = '0;
        end
      end
      ArbGrant: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (release_now) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          hold_cnt_d    = '0;
          rr_ptr_d      = grant_id_q;
          // Watchdog only reports when it alone caused the release.
          timeout_err_d = ~xfer_done & granted_req;
        end
      end
      ArbRelease: begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
      end
      default: begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios then random traffic, every cycle compared against
// a transaction-level model of owner / last-served / hold-count.
module tb_bus_rr_arbiter;

  localparam int CPUS    = 8;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            nRST;
  logic [CPUS-1:0] req;
  logic            bus_idle;
  logic            xfer_done;
  logic [CPUS-1:0] grant;
  logic            grant_valid;
  logic [2:0]      grant_id;
  logic            timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: current owner (-1 = none), last served, cycles held, one blocked cycle after release.
  int m_owner   = -1;
  int m_last    = CPUS - 1;
  int m_held    = 0;
  int m_blocked = 0;
  int m_id      = 0;
  int m_tmo     = 0;

  bus_rr_arbiter #(
    .CPUS(CPUS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .nRST(nRST),
    .req(req),
    .bus_idle(bus_idle),
    .xfer_done(xfer_done),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_edge(input logic [CPUS-1:0] r, input logic bi, input logic xd,
                            input logic rs);
    bit done;
    m_tmo = 0;
    if (rs) begin
      m_owner = -1; m_last = CPUS - 1; m_held = 0; m_blocked = 0; m_id = 0;
    end else if (m_owner >= 0) begin
      m_held++;
      done = xd || !r[m_owner];
      if (done || m_held == TIMEOUT) begin
        m_tmo     = done ? 0 : 1;
        m_last    = m_owner;
        m_owner   = -1;
        m_blocked = 1;
      end
    end else if (m_blocked != 0) begin
      m_blocked = 0;
    end else if (bi && r != 0) begin
      for (int k = 1; k <= CPUS; k++) begin
        if (m_owner < 0 && r[(m_last + k) % CPUS]) m_owner = (m_last + k) % CPUS;
      end
      m_id   = m_owner;
      m_held = 0;
    end
  endtask

  task automatic step(input logic [CPUS-1:0] r, input logic bi, input logic xd, input logic rs);
    logic [CPUS-1:0] eg;
    req = r; bus_idle = bi; xfer_done = xd; nRST = rs;
    @(posedge clk);
    model_edge(r, bi, xd, rs);
    #1;
    eg = (m_owner >= 0) ? (CPUS'(1) << m_owner) : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("grant_valid", 32'(grant_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("grant_id", 32'(grant_id), 32'(m_id));
    chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
  endtask

  task automatic wait_grant(input logic [CPUS-1:0] r, input logic bi);
    for (int k = 0; k < 40 && m_owner < 0; k++) step(r, bi, 1'b0, 1'b0);
    chk("wait_grant", 32'(grant_valid), 32'd1);
  endtask

  initial begin
    logic [CPUS-1:0] r;
    req = '0; bus_idle = 1'b0; xfer_done = 1'b0; nRST = 1'b1;

    // Reset and first grant: search starts at CPU0.
    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    step(8'b1000_0001, 1'b1, 1'b0, 1'b0);
    chk("first_grant", 32'(grant), 32'h01);
    step(8'b1000_0001, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);

    // Rotation with all requesting, xfer_done three cycles after each grant.
    step('0, 1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 9; g++) begin
      wait_grant(8'hFF, 1'b1);
      chk("rot_id", 32'(grant_id), 32'(g % CPUS));
      step(8'hFF, 1'b1, 1'b0, 1'b0);
      step(8'hFF, 1'b1, 1'b0, 1'b0);
      step(8'hFF, 1'b1, 1'b1, 1'b0);
      chk("rot_dead1", 32'(grant_valid), 32'd0);
      step(8'hFF, 1'b1, 1'b0, 1'b0);
      chk("rot_dead2", 32'(grant_valid), 32'd0);
    end

    // Wrap and skip: serve CPU6, then req 0010_0100 gives 2 then 5.
    step(8'h00, 1'b1, 1'b0, 1'b0);
    wait_grant(8'h40, 1'b1);
    step(8'h40, 1'b1, 1'b1, 1'b0);
    wait_grant(8'b0010_0100, 1'b1);
    chk("wrap_id", 32'(grant_id), 32'd2);
    step(8'b0010_0100, 1'b1, 1'b1, 1'b0);
    wait_grant(8'b0010_0100, 1'b1);
    chk("skip_id", 32'(grant_id), 32'd5);
    step(8'b0010_0100, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);

    // Bus busy gate.
    for (int k = 0; k < 5; k++) step(8'h10, 1'b0, 1'b0, 1'b0);
    chk("busy_gate", 32'(grant), 32'h00);
    step(8'h10, 1'b1, 1'b0, 1'b0);
    chk("busy_release", 32'(grant), 32'h10);
    step(8'h10, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);

    // Withdraw: CPU3 granted then drops its request.
    wait_grant(8'h08, 1'b1);
    step(8'h08, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    chk("withdraw_rel", 32'(grant_valid), 32'd0);
    chk("withdraw_tmo", 32'(timeout_err), 32'd0);
    step(8'h00, 1'b1, 1'b0, 1'b0);

    // Timeout: CPU4 held TIMEOUT cycles, then CPU5.
    wait_grant(8'h30, 1'b1);
    chk("tmo_id", 32'(grant_id), 32'd4);
    for (int k = 0; k < TIMEOUT - 1; k++) step(8'h30, 1'b1, 1'b0, 1'b0);
    chk("tmo_held", 32'(grant), 32'h10);
    step(8'h30, 1'b1, 1'b0, 1'b0);
    chk("tmo_pulse", 32'(timeout_err), 32'd1);
    step(8'h30, 1'b1, 1'b0, 1'b0);
    chk("tmo_single", 32'(timeout_err), 32'd0);
    wait_grant(8'h30, 1'b1);
    chk("tmo_next", 32'(grant_id), 32'd5);
    step(8'h30, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);

    // xfer_done, then withdrawal, coinciding with the last watchdog cycle.
    for (int v = 0; v < 2; v++) begin
      wait_grant(8'h02, 1'b1);
      for (int k = 0; k < TIMEOUT - 1; k++) step(8'h02, 1'b1, 1'b0, 1'b0);
      if (v == 0) step(8'h02, 1'b1, 1'b1, 1'b0);
      else step(8'h00, 1'b1, 1'b0, 1'b0);
      chk("simul_tmo", 32'(timeout_err), 32'd0);
      chk("simul_rel", 32'(grant_valid), 32'd0);
      step(8'h00, 1'b1, 1'b0, 1'b0);
    end

    // Reset mid-grant: pointer back to CPU7, so next grant is CPU0.
    wait_grant(8'h40, 1'b1);
    step(8'h40, 1'b1, 1'b0, 1'b0);
    step(8'h40, 1'b1, 1'b0, 1'b1);
    chk("rst_grant", 32'(grant), 32'h00);
    chk("rst_id", 32'(grant_id), 32'd0);
    wait_grant(8'hFF, 1'b1);
    chk("rst_ptr", 32'(grant_id), 32'd0);
    step(8'hFF, 1'b1, 1'b1, 1'b0);

    // Random traffic with mostly-held requests.
    r = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7, 0) == 0) r = 8'($urandom) & 8'($urandom);
      step(r, $urandom_range(3, 0) != 0, $urandom_range(5, 0) == 0,
           $urandom_range(499, 0) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin arbiter for the shared coherence bus controller. Collects per-CPU bus requests from the L1 caches, grants exactly one requester at a time, and holds the grant until the bus controller reports transaction completion, the requester withdraws, or a watchdog expires. Sits between the L1 coherence request lines and the bus controller's request-select input, so the controller only ever sees one active requester.

## Interface
Parameters:
- CPUS, 8, number of requesting L1 caches
- CPU_ID_LENGTH, $clog2(CPUS), width of requester ID
- TIMEOUT, 1024, max cycles a grant is held before forced release (≥2)

Ports:
- clk  input  1  bus clock; all state updates on rising edge
- nRST  input  1  reset; synchronous, active-high (asserted = 1 resets on next rising edge)
- req  input  CPUS  per-CPU request (cctrans | dREN | dWEN of that L1); level, held until granted and served
- bus_idle  input  1  bus controller is in IDLE and can accept a new transaction
- xfer_done  input  1  single-cycle pulse: current granted transaction finished
- grant  output  CPUS  one-hot grant, registered
- grant_valid  output  1  OR of grant, registered
- grant_id  output  CPU_ID_LENGTH  binary index of granted CPU; holds last granted ID when grant_valid=0
- timeout_err  output  1  single-cycle pulse on watchdog expiry

## Operation
- Reset values: grant=0, grant_valid=0, grant_id=0, timeout_err=0, state=ARB_IDLE, rr_ptr=CPUS-1, hold_cnt=0.
- rr_ptr holds the index of the last served CPU; search order is rr_ptr+1, rr_ptr+2, … modulo CPUS, wrapping from CPUS-1 to 0.
- States:
  - ARB_IDLE: if bus_idle=1 and req≠0, select first set bit in search order; register grant/grant_id; hold_cnt←0; → ARB_GRANT. Otherwise stay, grant=0.
  - ARB_GRANT: grant_valid=1, grant stable. hold_cnt increments each cycle.
    - xfer_done=1 → ARB_RELEASE.
    - else req[grant_id]=0 (withdrawn) → ARB_RELEASE.
    - else hold_cnt=TIMEOUT-1 → timeout_err=1 for the next cycle, → ARB_RELEASE.
    - Priority when simultaneous: xfer_done > withdraw > timeout; timeout_err only fires if neither of the others is present.
  - ARB_RELEASE: grant=0, grant_valid=0; rr_ptr←grant_id; → ARB_IDLE.
- rr_ptr updates on every exit from ARB_GRANT, regardless of cause, so a timed-out or withdrawn requester loses priority.
- xfer_done while in ARB_IDLE or ARB_RELEASE is ignored.
- req bits changing during ARB_GRANT for non-granted CPUs have no effect until next ARB_IDLE.
- bus_idle is sampled only in ARB_IDLE.
- Single requester repeatedly requesting is granted every round (no self-starvation).
- Fairness: with all CPUS requesting continuously, each CPU is granted exactly once per CPUS grants.

## Timing
- Request latency: req and bus_idle high at edge N (in ARB_IDLE) → grant visible after edge N (cycle N+1).
- Release: xfer_done sampled at edge T → grant low in cycle T+1 (ARB_RELEASE), ARB_IDLE in T+2, next grant visible T+3 at earliest. Two dead cycles minimum between grants.
- Watchdog: grant cycles counted 0..TIMEOUT-1; grant held exactly TIMEOUT cycles, timeout_err high in the first ARB_RELEASE cycle.
- Reset mid-operation: nRST=1 at any edge forces reset values on that edge, including mid-grant; hold_cnt cleared; no timeout_err pulse.
- grant, grant_valid, grant_id change only on clock edges; no combinational path from req to grant.

## Test plan
- Reset/first grant: after reset, req=8'b1000_0001, bus_idle=1 → grant=8'b0000_0001, grant_id=0 one cycle later (rr_ptr=7 starts search at 0).
- Round-robin rotation: req=8'hFF held, xfer_done pulsed 3 cycles after each grant → grant_id sequence 0,1,2,…,7,0 with exactly 2 idle cycles between grants.
- Wrap and skip: rr_ptr=6 (last served CPU6), req=8'b0010_0100 → grant_id=2 (search 7,0,1,2); next round grant_id=5.
- Bus busy gate: req=8'h10, bus_idle=0 for 5 cycles → grant stays 0; bus_idle→1 at edge N → grant=8'h10 at N+1.
- Withdraw and timeout: CPU3 granted then req[3]→0 → release next cycle, no timeout_err; separately TIMEOUT=16, CPU4 granted, no xfer_done → grant held 16 cycles, timeout_err=1 one cycle, then next requester CPU5 granted.
- Simultaneous events and reset: xfer_done and req withdrawal on the same edge as hold_cnt=TIMEOUT-1 → release with timeout_err=0; nRST=1 mid-grant → grant=0, grant_id=0 next cycle, rr_ptr=7.
